// File: rtl/compute_core.sv
// Word-serial vector engine over a 1024x64 memory with an external access port and a one-deep command queue.
// Optional feature: define COMPUTE_CORE_TRNG_EN to build the LFSR random source used by opcode 6.
module compute_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  address_ext,
  input  logic [63:0] dina_ext,
  input  logic        wea_ext,
  input  logic [34:0] command_in,
  input  logic        command_we0,
  input  logic        command_we1,
  output logic [63:0] doutb_ext,
  output logic        done_ins_computation,
  output logic        error_trng
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  logic [63:0] mem_r [0:1023];
  state_t      state_r, state_s;
  logic        done_r, start_s, take_pend_s;
  logic [34:0] start_cmd_s, pend_cmd_r;
  logic        pend_valid_r;
  logic [2:0]  op_r;
  logic [9:0]  dst_r, a_r, b_r;
  logic [7:0]  last_r, idx_r;
  logic [1:0]  drain_r;
  logic [15:0] carry_r, carry_in_s, a_last_top_s;
  logic [9:0]  addr_a_s, addr_b_s, addr_d_s, addr_last_s;
  logic [63:0] wa_s, wb_s, res_s, doutb_r;

  function automatic logic [7:0] len_last(input logic [1:0] len);
    case (len)
      2'b00:   len_last = 8'd255;
      2'b01:   len_last = 8'd127;
      2'b10:   len_last = 8'd63;
      default: len_last = 8'd31;
    endcase
  endfunction

  function automatic logic is_nop(input logic [2:0] op);
`ifdef COMPUTE_CORE_TRNG_EN
    is_nop = (op == 3'd0) || (op == 3'd7);
`else
    is_nop = (op == 3'd0) || (op == 3'd6) || (op == 3'd7);
`endif
  endfunction

  function automatic logic [63:0] lane_arith(input logic [63:0] a, input logic [63:0] b,
                                             input logic sub);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < 4; k++) begin
      if (sub) r[16*k +: 16] = a[16*k +: 16] - b[16*k +: 16];
      else     r[16*k +: 16] = a[16*k +: 16] + b[16*k +: 16];
    end
    return r;
  endfunction

`ifdef COMPUTE_CORE_TRNG_EN
  logic [63:0] lfsr_r, lfsr_next_s;
  logic        err_r;
  assign lfsr_next_s = {lfsr_r[62:0], lfsr_r[63] ^ lfsr_r[62] ^ lfsr_r[60] ^ lfsr_r[59]};

  // Free-running source plus sticky health monitor (stuck output or all-zero)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= 64'h0123_4567_89AB_CDEF;
      err_r  <= 1'b0;
    end else begin
      lfsr_r <= lfsr_next_s;
      err_r  <= err_r | (lfsr_next_s == lfsr_r) | (lfsr_next_s == 64'd0);
    end
  end
  assign error_trng = err_r;
`else
  assign error_trng = 1'b0;
`endif

  // Operands are read combinationally and written back the same cycle, so overlapping
  // regions see strict word-by-word order; the rotate carry uses the original source word.
  assign addr_a_s     = a_r + {2'b00, idx_r};
  assign addr_b_s     = b_r + {2'b00, idx_r};
  assign addr_d_s     = dst_r + {2'b00, idx_r};
  assign addr_last_s  = a_r + {2'b00, last_r};
  assign wa_s         = mem_r[addr_a_s];
  assign wb_s         = mem_r[addr_b_s];
  assign a_last_top_s = mem_r[addr_last_s][63:48];
  assign carry_in_s   = (idx_r == 8'd0) ? (16'd0 - a_last_top_s) : carry_r;

  // Per-word result selection
  always_comb begin
    res_s = wa_s;
    case (op_r)
      3'd1:    res_s = lane_arith(wa_s, wb_s, 1'b0);
      3'd2:    res_s = lane_arith(wa_s, wb_s, 1'b1);
      3'd3:    res_s = wa_s ^ wb_s;
      3'd4:    res_s = wa_s;
      3'd5:    res_s = {wa_s[47:0], carry_in_s};
`ifdef COMPUTE_CORE_TRNG_EN
      3'd6:    res_s = lfsr_r;
`endif
      default: res_s = wa_s;
    endcase
  end

  // Next state: launch from IDLE or straight out of DRAIN when a command is pending
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    take_pend_s = 1'b0;
    start_cmd_s = command_in;
    case (state_r)
      IDLE: begin
        if (command_we0) begin
          start_s = 1'b1;
        end else if (pend_valid_r) begin
          start_s     = 1'b1;
          take_pend_s = 1'b1;
          start_cmd_s = pend_cmd_r;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == last_r) state_s = DRAIN;
        else                 state_s = RUN;
      end
      DRAIN: begin
        if (drain_r != 2'd2) begin
          state_s = DRAIN;
        end else if (pend_valid_r) begin
          start_s     = 1'b1;
          take_pend_s = 1'b1;
          start_cmd_s = pend_cmd_r;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
    // A no-op enters DRAIN on its final count so it retires after one cycle
    state_s = start_s ? (is_nop(start_cmd_s[34:32]) ? DRAIN : RUN) : state_s;
  end

  // State register and idle flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      done_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == IDLE);
    end
  end

  // Instruction registers, word/drain counters and the pending slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_cmd_r   <= 35'd0;
      op_r         <= 3'd0;
      dst_r        <= 10'd0;
      a_r          <= 10'd0;
      b_r          <= 10'd0;
      last_r       <= 8'd0;
      idx_r        <= 8'd0;
      drain_r      <= 2'd0;
      carry_r      <= 16'd0;
    end else begin
      if (command_we1 && !command_we0) begin
        pend_valid_r <= 1'b1;
        pend_cmd_r   <= command_in;
      end else if (take_pend_s) begin
        pend_valid_r <= 1'b0;
      end
      if (start_s) begin
        op_r    <= start_cmd_s[34:32];
        dst_r   <= start_cmd_s[31:22];
        a_r     <= start_cmd_s[21:12];
        b_r     <= start_cmd_s[11:2];
        last_r  <= len_last(start_cmd_s[1:0]);
        idx_r   <= 8'd0;
        drain_r <= 2'd2;
      end else if (state_r == RUN) begin
        idx_r   <= idx_r + 8'd1;
        drain_r <= 2'd0;
      end else if (state_r == DRAIN) begin
        drain_r <= drain_r + 2'd1;
      end
      if (state_r == RUN) carry_r <= wa_s[63:48];
    end
  end

  // Memory array: core owns the write port while busy, external port while idle
  always_ff @(posedge clk) begin
    if (state_r == RUN) begin
      mem_r[addr_d_s] <= res_s;
    end else if (wea_ext && (state_r == IDLE)) begin
      mem_r[address_ext] <= dina_ext;
    end
  end

  // External registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) doutb_r <= 64'd0;
    else      doutb_r <= mem_r[address_ext];
  end

  assign doutb_ext            = doutb_r;
  assign done_ins_computation = done_r;

endmodule

// File: tb/tb_compute_core.sv
// Self-checking bench for compute_core: random memory contents, directed instruction sequence,
// word-level reference model of the instruction set.
module tb_compute_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  address_ext;
  logic [63:0] dina_ext;
  logic        wea_ext;
  logic [34:0] command_in;
  logic        command_we0, command_we1;
  logic [63:0] doutb_ext;
  logic        done_ins_computation;
  logic        error_trng;

  compute_core dut (
    .clk(clk), .rst(rst), .address_ext(address_ext), .dina_ext(dina_ext), .wea_ext(wea_ext),
    .command_in(command_in), .command_we0(command_we0), .command_we1(command_we1),
    .doutb_ext(doutb_ext), .done_ins_computation(done_ins_computation), .error_trng(error_trng)
  );

  always #5 clk = ~clk;

  logic [63:0] model [0:1023];
  int n_checks = 0;
  int n_fails  = 0;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] mk(input int op, input int dst, input int a, input int b, input int len);
    return {op[2:0], dst[9:0], a[9:0], b[9:0], len[1:0]};
  endfunction

  // Reference: sequential word-by-word semantics, words seen as four 16-bit coefficients
  task automatic model_exec(input int op, input int dst, input int a, input int b,
                            input int len, input int lim);
    int n;
    logic [15:0] coef [0:1023];
    logic [15:0] ca, cb, cr;
    logic [63:0] w;
    n = 256 >> len;
    if (lim > n) lim = n;
    if (op == 5) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) coef[4*i+k] = model[(a+i)%1024][16*k +: 16];
      for (int i = 0; i < lim; i++) begin
        for (int k = 0; k < 4; k++)
          w[16*k +: 16] = (i == 0 && k == 0) ? (16'd0 - coef[4*n-1]) : coef[4*i+k-1];
        model[(dst+i)%1024] = w;
      end
    end else if (op >= 1 && op <= 4) begin
      for (int i = 0; i < lim; i++) begin
        for (int k = 0; k < 4; k++) begin
          ca = model[(a+i)%1024][16*k +: 16];
          cb = model[(b+i)%1024][16*k +: 16];
          case (op)
            1:       cr = ca + cb;
            2:       cr = ca - cb;
            3:       cr = ca ^ cb;
            default: cr = ca;
          endcase
          w[16*k +: 16] = cr;
        end
        model[(dst+i)%1024] = w;
      end
    end
  endtask

  task automatic ext_write(input int addr, input logic [63:0] data);
    address_ext = 10'(addr);
    dina_ext    = data;
    wea_ext     = 1'b1;
    @(posedge clk); #1;
    wea_ext     = 1'b0;
    model[addr%1024] = data;
  endtask

  task automatic readback(input int base, input int cnt, input string tag);
    for (int i = 0; i < cnt; i++) begin
      address_ext = 10'((base + i) % 1024);
      @(posedge clk); #1;
      check(tag, doutb_ext, model[(base+i)%1024]);
    end
  endtask

  task automatic issue(input logic [34:0] cmd, input logic w0, input logic w1);
    command_in  = cmd;
    command_we0 = w0;
    command_we1 = w1;
    @(posedge clk); #1;
    command_we0 = 1'b0;
    command_we1 = 1'b0;
  endtask

  task automatic wait_done(input int exp, input string tag);
    int cyc;
    cyc = 0;
    while (done_ins_computation !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, 64'(cyc), 64'(exp));
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] rw [0:31];
    int dups;
    rst = 1'b0; address_ext = 10'd0; dina_ext = 64'd0; wea_ext = 1'b0;
    command_in = 35'd0; command_we0 = 1'b0; command_we1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(done_ins_computation), 64'd1);
    check("rst_dout", doutb_ext, 64'd0);
    check("rst_err", 64'(error_trng), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 1024; i++) begin
      if (i < 256)      w = 64'(i);
      else if (i < 512) w = 64'h0001_0001_0001_0001;
      else              w = {$urandom, $urandom};
      ext_write(i, w);
    end

    // ADD, full length
    issue(mk(1, 512, 0, 256, 0), 1'b1, 1'b0);
    check("add_fall", 64'(done_ins_computation), 64'd0);
    wait_done(259, "add_latency");
    model_exec(1, 512, 0, 256, 0, 1024);
    readback(512, 256, "add_data");

    // SUB of a region with itself, then lane wrap
    issue(mk(2, 768, 256, 256, 3), 1'b1, 1'b0);
    wait_done(35, "sub0_latency");
    model_exec(2, 768, 256, 256, 3, 1024);
    readback(768, 32, "sub0_data");
    ext_write(900, 64'd0);
    ext_write(901, 64'h0001_0001_0001_0001);
    issue(mk(2, 940, 900, 901, 3), 1'b1, 1'b0);
    wait_done(35, "subw_latency");
    model_exec(2, 940, 900, 901, 3, 1024);
    readback(940, 32, "subw_data");
    address_ext = 10'd940;
    @(posedge clk); #1;
    check("sub_wrap_word0", doutb_ext, 64'hFFFF_FFFF_FFFF_FFFF);

    // XOR with destination wrapping past the top of memory
    issue(mk(3, 1000, 0, 512, 2), 1'b1, 1'b0);
    wait_done(67, "xor_latency");
    model_exec(3, 1000, 0, 512, 2, 1024);
    readback(1000, 64, "xor_data");

    // COPY with dest = src+1: in-order semantics smear word 0
    issue(mk(4, 601, 600, 0, 1), 1'b1, 1'b0);
    wait_done(131, "copy_latency");
    model_exec(4, 601, 600, 0, 1, 1024);
    readback(600, 129, "copy_data");

    // NEGROT queued while idle through the pending slot
    w = {$urandom, $urandom};
    ext_write(591, {16'h0005, w[47:0]});
    issue(mk(5, 700, 560, 0, 3), 1'b0, 1'b1);
    check("we1_idle_hold", 64'(done_ins_computation), 64'd1);
    @(posedge clk); #1;
    check("we1_idle_fall", 64'(done_ins_computation), 64'd0);
    wait_done(35, "negrot_latency");
    model_exec(5, 700, 560, 0, 3, 1024);
    readback(700, 32, "negrot_data");
    address_ext = 10'd700;
    @(posedge clk); #1;
    check("negrot_c0", 64'(doutb_ext[15:0]), 64'h0000_0000_0000_FFFB);

    // NOP and reserved opcode retire in one cycle
    issue(mk(0, 100, 0, 0, 0), 1'b1, 1'b0);
    check("nop_fall", 64'(done_ins_computation), 64'd0);
    wait_done(1, "nop_latency");
    issue(mk(7, 100, 0, 0, 0), 1'b1, 1'b0);
    wait_done(1, "rsvd_latency");

    // we0 and we1 together: only one execution
    issue(mk(3, 470, 10, 20, 3), 1'b1, 1'b1);
    wait_done(35, "both_latency");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("both_no_second", 64'(done_ins_computation), 64'd1);
    end
    model_exec(3, 470, 10, 20, 3, 1024);
    readback(470, 32, "both_data");

    // Pending overwrite and busy we0 ignored; done stays low across the handoff
    issue(mk(1, 512, 600, 650, 3), 1'b1, 1'b0);
    check("pend_fall", 64'(done_ins_computation), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(mk(3, 800, 0, 1, 3), 1'b0, 1'b1);
    issue(mk(4, 950, 256, 0, 3), 1'b1, 1'b0);
    issue(mk(4, 860, 0, 0, 2), 1'b0, 1'b1);
    wait_done(96, "pend_chain_latency");
    model_exec(1, 512, 600, 650, 3, 1024);
    model_exec(4, 860, 0, 0, 2, 1024);
    readback(512, 32, "pend_add");
    readback(800, 32, "pend_overwritten");
    readback(860, 64, "pend_copy");
    readback(950, 32, "busy_we0_ignored");

    // Reset in the middle of RUN keeps the words already written
    issue(mk(2, 512, 0, 256, 0), 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_done", 64'(done_ins_computation), 64'd1);
    check("midrst_dout", doutb_ext, 64'd0);
    check("midrst_err", 64'(error_trng), 64'd0);
    model_exec(2, 512, 0, 256, 0, 20);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle", 64'(done_ins_computation), 64'd1);
    ext_write(612, {$urandom, $urandom});
    readback(512, 128, "postrst_data");

    // RAND
`ifdef COMPUTE_CORE_TRNG_EN
    issue(mk(6, 970, 0, 0, 3), 1'b1, 1'b0);
    wait_done(35, "rand_latency");
    for (int i = 0; i < 32; i++) begin
      address_ext = 10'(970 + i);
      @(posedge clk); #1;
      rw[i] = doutb_ext;
      check("rand_nonzero", 64'(rw[i] != 64'd0), 64'd1);
    end
    dups = 0;
    for (int i = 0; i < 32; i++)
      for (int j = i + 1; j < 32; j++)
        if (rw[i] == rw[j]) dups++;
    check("rand_distinct", 64'(dups), 64'd0);
    check("rand_err", 64'(error_trng), 64'd0);
`else
    issue(mk(6, 970, 0, 0, 3), 1'b1, 1'b0);
    check("rand_fall", 64'(done_ins_computation), 64'd0);
    wait_done(1, "rand_nop_latency");
    readback(970, 32, "rand_unchanged");
    check("rand_err_tied", 64'(error_trng), 64'd0);
    rw[0] = 64'd0;
    dups  = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
